// File: rtl/riscv_mem.sv
// rtl/riscv_mem.sv - RISC-V memory-access stage: loads/stores over req/gnt/rvalid, branch resolve, WB pulse
module riscv_mem #(
    parameter int REGFILE_COUNT = 32,
    parameter int WORD_SIZE     = 32
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             ex_valid_i,
    output logic                             ex_ready_o,
    input  logic [WORD_SIZE-1:0]             alu_out_i,
    input  logic                             alu_zero_i,
    input  logic [WORD_SIZE-1:0]             read_data1_i,
    input  logic [WORD_SIZE-1:0]             jp_addr_i,
    input  logic [$clog2(REGFILE_COUNT)-1:0] write_reg_i,
    input  logic                             reg_write_i,
    input  logic                             mem_read_i,
    input  logic                             mem_write_i,
    input  logic                             branch_i,
    input  logic [1:0]                       mem_size_i,
    input  logic                             mem_unsigned_i,
    output logic                             dmem_req_o,
    output logic                             dmem_we_o,
    output logic [WORD_SIZE-1:0]             dmem_addr_o,
    output logic [3:0]                       dmem_be_o,
    output logic [WORD_SIZE-1:0]             dmem_wdata_o,
    input  logic                             dmem_gnt_i,
    input  logic                             dmem_rvalid_i,
    input  logic [WORD_SIZE-1:0]             dmem_rdata_i,
    output logic                             wb_valid_o,
    output logic                             wb_reg_write_o,
    output logic [WORD_SIZE-1:0]             wb_data_o,
    output logic [$clog2(REGFILE_COUNT)-1:0] wb_write_reg_o,
    output logic                             branch_taken_o,
    output logic [WORD_SIZE-1:0]             branch_target_o,
    output logic                             misaligned_o
);

    localparam int REG_W = $clog2(REGFILE_COUNT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT
    } state_t;

    state_t             state;
    logic [1:0]         lat_off;
    logic [1:0]         lat_size;
    logic               lat_unsigned;
    logic               lat_reg_write;
    logic               lat_store;
    logic [REG_W-1:0]   lat_write_reg;

    logic [1:0]           ex_off;
    logic                 ex_is_mem;
    logic                 ex_misaligned;
    logic                 ex_take_branch;
    logic [3:0]           ex_be;
    logic [WORD_SIZE-1:0] ex_wdata;

    logic [7:0]           ld_byte;
    logic [15:0]          ld_half;
    logic [WORD_SIZE-1:0] ld_value;

    assign ex_ready_o     = (state == S_IDLE);
    assign ex_off         = alu_out_i[1:0];
    assign ex_is_mem      = mem_read_i | mem_write_i;
    assign ex_take_branch = branch_i & alu_zero_i;

    // Byte enables and lane-replicated store data for the accepted bundle
    always_comb begin
        ex_misaligned = 1'b0;
        ex_be         = 4'b1111;
        ex_wdata      = read_data1_i;
        case (mem_size_i)
            2'b00: begin
                ex_be    = 4'b0001 << ex_off;
                ex_wdata = {4{read_data1_i[7:0]}};
            end
            2'b01: begin
                ex_misaligned = ex_off[0];
                ex_be         = 4'b0011 << ex_off;
                ex_wdata      = {2{read_data1_i[15:0]}};
            end
            default: begin
                ex_misaligned = |ex_off;
            end
        endcase
    end

    // Lane extraction uses only the offset/size latched at accept
    always_comb begin
        ld_byte = 8'h00;
        case (lat_off)
            2'd0:    ld_byte = dmem_rdata_i[7:0];
            2'd1:    ld_byte = dmem_rdata_i[15:8];
            2'd2:    ld_byte = dmem_rdata_i[23:16];
            default: ld_byte = dmem_rdata_i[31:24];
        endcase
        ld_half = lat_off[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
        ld_value = dmem_rdata_i;
        case (lat_size)
            2'b00: begin
                if (lat_unsigned) begin
                    ld_value = {{(WORD_SIZE-8){1'b0}}, ld_byte};
                end else begin
                    ld_value = {{(WORD_SIZE-8){ld_byte[7]}}, ld_byte};
                end
            end
            2'b01: begin
                if (lat_unsigned) begin
                    ld_value = {{(WORD_SIZE-16){1'b0}}, ld_half};
                end else begin
                    ld_value = {{(WORD_SIZE-16){ld_half[15]}}, ld_half};
                end
            end
            default: ld_value = dmem_rdata_i;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state           <= S_IDLE;
            lat_off         <= '0;
            lat_size        <= '0;
            lat_unsigned    <= 1'b0;
            lat_reg_write   <= 1'b0;
            lat_store       <= 1'b0;
            lat_write_reg   <= '0;
            dmem_req_o      <= 1'b0;
            dmem_we_o       <= 1'b0;
            dmem_addr_o     <= '0;
            dmem_be_o       <= '0;
            dmem_wdata_o    <= '0;
            wb_valid_o      <= 1'b0;
            wb_reg_write_o  <= 1'b0;
            wb_data_o       <= '0;
            wb_write_reg_o  <= '0;
            branch_taken_o  <= 1'b0;
            branch_target_o <= '0;
            misaligned_o    <= 1'b0;
        end else begin
            wb_valid_o     <= 1'b0;
            branch_taken_o <= 1'b0;
            misaligned_o   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (ex_valid_i) begin
                        lat_off       <= ex_off;
                        lat_size      <= mem_size_i;
                        lat_unsigned  <= mem_unsigned_i;
                        lat_reg_write <= reg_write_i;
                        lat_store     <= mem_write_i;
                        lat_write_reg <= write_reg_i;
                        if (!ex_is_mem) begin
                            wb_valid_o     <= 1'b1;
                            wb_data_o      <= alu_out_i;
                            wb_write_reg_o <= write_reg_i;
                            wb_reg_write_o <= reg_write_i & ~ex_take_branch;
                            if (ex_take_branch) begin
                                branch_taken_o  <= 1'b1;
                                branch_target_o <= jp_addr_i;
                            end
                        end else if (ex_misaligned) begin
                            wb_valid_o     <= 1'b1;
                            wb_reg_write_o <= 1'b0;
                            wb_write_reg_o <= write_reg_i;
                            misaligned_o   <= 1'b1;
                        end else begin
                            // Read+write together is treated as a store
                            dmem_req_o   <= 1'b1;
                            dmem_we_o    <= mem_write_i;
                            dmem_addr_o  <= {alu_out_i[WORD_SIZE-1:2], 2'b00};
                            dmem_be_o    <= ex_be;
                            dmem_wdata_o <= ex_wdata;
                            state        <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (dmem_gnt_i) begin
                        dmem_req_o <= 1'b0;
                        if (lat_store) begin
                            wb_valid_o     <= 1'b1;
                            wb_reg_write_o <= 1'b0;
                            wb_write_reg_o <= lat_write_reg;
                            state          <= S_IDLE;
                        end else begin
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (dmem_rvalid_i) begin
                        wb_valid_o     <= 1'b1;
                        wb_data_o      <= ld_value;
                        wb_reg_write_o <= lat_reg_write;
                        wb_write_reg_o <= lat_write_reg;
                        state          <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_mem.sv
// tb/tb_riscv_mem.sv - randomized bench for riscv_mem against a per-cycle transaction model
module tb_riscv_mem;

    localparam int MAXC = 8000;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        ex_valid_i;
    logic        ex_ready_o;
    logic [31:0] alu_out_i;
    logic        alu_zero_i;
    logic [31:0] read_data1_i;
    logic [31:0] jp_addr_i;
    logic [4:0]  write_reg_i;
    logic        reg_write_i, mem_read_i, mem_write_i, branch_i;
    logic [1:0]  mem_size_i;
    logic        mem_unsigned_i;
    logic        dmem_req_o, dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_gnt_i, dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;
    logic        wb_valid_o, wb_reg_write_o;
    logic [31:0] wb_data_o;
    logic [4:0]  wb_write_reg_o;
    logic        branch_taken_o;
    logic [31:0] branch_target_o;
    logic        misaligned_o;

    riscv_mem #(.REGFILE_COUNT(32), .WORD_SIZE(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o),
        .alu_out_i(alu_out_i), .alu_zero_i(alu_zero_i),
        .read_data1_i(read_data1_i), .jp_addr_i(jp_addr_i),
        .write_reg_i(write_reg_i), .reg_write_i(reg_write_i),
        .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
        .branch_i(branch_i), .mem_size_i(mem_size_i),
        .mem_unsigned_i(mem_unsigned_i),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
        .dmem_addr_o(dmem_addr_o), .dmem_be_o(dmem_be_o),
        .dmem_wdata_o(dmem_wdata_o), .dmem_gnt_i(dmem_gnt_i),
        .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
        .wb_valid_o(wb_valid_o), .wb_reg_write_o(wb_reg_write_o),
        .wb_data_o(wb_data_o), .wb_write_reg_o(wb_write_reg_o),
        .branch_taken_o(branch_taken_o), .branch_target_o(branch_target_o),
        .misaligned_o(misaligned_o)
    );

    initial forever #5 clk_i = ~clk_i;

    typedef struct {
        bit rdy, wb, rw, chkd, br, mis, req, we, chkw;
        logic [31:0] data, tgt, addr, wdata;
        logic [3:0]  be;
        logic [4:0]  wreg;
    } exp_t;

    typedef struct {
        logic [31:0] alu, st_data, jp, rdat;
        logic [4:0]  wreg;
        bit          zero, rw, mr, mw, br, uns;
        logic [1:0]  size;
        int          g, r;
    } txn_t;

    exp_t ex [MAXC];
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    bit   done = 1'b0;
    logic [31:0] seen_addr, seen_wdata;
    logic [3:0]  seen_be;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, expv);
        end
    endtask

    function automatic int nbytes(input logic [1:0] s);
        return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [3:0] m_be(input int a, input int n);
        logic [3:0] be;
        for (int i = 0; i < 4; i++) be[i] = (i >= a) && (i < a + n);
        return be;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [31:0] d, input int n);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % n) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] rd, input int a, input int n, input bit uns);
        logic [31:0] v, mask;
        mask = (n == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * n)) - 32'h1);
        v = (rd >> (8 * a)) & mask;
        if (!uns && n < 4 && v[8*n-1]) v = v | ~mask;
        return v;
    endfunction

    // Every cycle: DUT outputs against the expectation timeline built by run_txn
    always @(negedge clk_i) begin
        exp_t e;
        if (cyc >= 1 && cyc < MAXC && !done) begin
            e = ex[cyc];
            chk("ex_ready", ex_ready_o, e.rdy);
            chk("wb_valid", wb_valid_o, e.wb);
            if (e.wb) begin
                chk("wb_reg_write", wb_reg_write_o, e.rw);
                chk("wb_write_reg", wb_write_reg_o, e.wreg);
                if (e.chkd) chk("wb_data", wb_data_o, e.data);
            end
            chk("branch_taken", branch_taken_o, e.br);
            if (e.br) chk("branch_target", branch_target_o, e.tgt);
            chk("misaligned", misaligned_o, e.mis);
            chk("dmem_req", dmem_req_o, e.req);
            if (e.req) begin
                chk("dmem_we", dmem_we_o, e.we);
                chk("dmem_addr", dmem_addr_o, e.addr);
                chk("dmem_be", dmem_be_o, e.be);
                if (e.chkw) chk("dmem_wdata", dmem_wdata_o, e.wdata);
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic noise();
        dmem_gnt_i    = 1'($urandom % 2);
        dmem_rvalid_i = 1'($urandom % 2);
        dmem_rdata_i  = $urandom;
    endtask

    task automatic garbage();
        ex_valid_i     = 1'($urandom % 2);
        alu_out_i      = $urandom;
        alu_zero_i     = 1'($urandom % 2);
        read_data1_i   = $urandom;
        jp_addr_i      = $urandom;
        write_reg_i    = 5'($urandom);
        reg_write_i    = 1'($urandom % 2);
        mem_read_i     = 1'($urandom % 2);
        mem_write_i    = 1'($urandom % 2);
        branch_i       = 1'($urandom % 2);
        mem_size_i     = 2'($urandom);
        mem_unsigned_i = 1'($urandom % 2);
    endtask

    function automatic txn_t mk();
        txn_t t;
        t = '{default: 0};
        return t;
    endfunction

    task automatic run_txn(input txn_t t);
        int c, n, a, e;
        bit mem, mis, taken;
        c     = cyc;
        n     = nbytes(t.size);
        a     = int'(t.alu[1:0]);
        mem   = t.mr | t.mw;
        mis   = mem && (a % n != 0);
        taken = !mem && t.br && t.zero;
        if (!mem || mis) begin
            e = c + 1;
            ex[e].wb = 1; ex[e].rw = (mis || taken) ? 1'b0 : t.rw; ex[e].wreg = t.wreg;
            ex[e].chkd = !mis; ex[e].data = t.alu;
            ex[e].br = taken; ex[e].tgt = t.jp; ex[e].mis = mis;
        end else begin
            for (int k = c + 1; k <= c + 1 + t.g; k++) begin
                ex[k].req = 1; ex[k].we = t.mw; ex[k].addr = {t.alu[31:2], 2'b00};
                ex[k].be = m_be(a, n); ex[k].wdata = m_wdata(t.st_data, n);
                ex[k].chkw = t.mw; ex[k].rdy = 0;
            end
            if (t.mw) begin
                e = c + 2 + t.g;
                ex[e].wb = 1; ex[e].rw = 0; ex[e].wreg = t.wreg; ex[e].chkd = 0;
            end else begin
                for (int k = c + 2 + t.g; k <= c + 2 + t.g + t.r; k++) ex[k].rdy = 0;
                e = c + 3 + t.g + t.r;
                ex[e].wb = 1; ex[e].rw = t.rw; ex[e].wreg = t.wreg; ex[e].chkd = 1;
                ex[e].data = m_load(t.rdat, a, n, t.uns);
            end
        end
        ex_valid_i = 1; alu_out_i = t.alu; alu_zero_i = t.zero; read_data1_i = t.st_data;
        jp_addr_i = t.jp; write_reg_i = t.wreg; reg_write_i = t.rw; mem_read_i = t.mr;
        mem_write_i = t.mw; branch_i = t.br; mem_size_i = t.size; mem_unsigned_i = t.uns;
        noise();
        step();
        if (mem && !mis) begin
            for (int k = 0; k <= t.g; k++) begin
                if (k > 0) step();
                if (k == 0) begin
                    seen_addr = dmem_addr_o; seen_be = dmem_be_o; seen_wdata = dmem_wdata_o;
                end
                garbage(); noise();
                dmem_gnt_i = (k == t.g);
            end
            step();
            if (!t.mw) begin
                for (int k = 0; k <= t.r; k++) begin
                    if (k > 0) step();
                    garbage(); noise();
                    dmem_rvalid_i = (k == t.r);
                    if (k == t.r) dmem_rdata_i = t.rdat;
                end
                step();
            end
        end
        ex_valid_i = 0;
        noise();
    endtask

    initial begin
        txn_t t;
        int   c, n;
        for (int i = 0; i < MAXC; i++) begin
            ex[i] = '{default: 0};
            ex[i].rdy = 1;
        end
        rst_i = 1;
        garbage();
        ex_valid_i = 0; dmem_gnt_i = 0; dmem_rvalid_i = 0; dmem_rdata_i = 0;
        step();
        step();
        chk("rst_ex_ready", ex_ready_o, 1);
        chk("rst_dmem_req", dmem_req_o, 0);
        chk("rst_dmem_addr", dmem_addr_o, 0);
        chk("rst_dmem_be", dmem_be_o, 0);
        chk("rst_wb_data", wb_data_o, 0);
        chk("rst_branch_target", branch_target_o, 0);
        rst_i = 0;
        ex_valid_i = 0;
        step();

        t = mk(); t.alu = 32'h0000_1234; t.wreg = 5; t.rw = 1;
        run_txn(t);
        chk("alu_wb_valid", wb_valid_o, 1);
        chk("alu_wb_data", wb_data_o, 32'h0000_1234);
        chk("alu_wb_reg", wb_write_reg_o, 5);

        t = mk(); t.alu = 32'h103; t.st_data = 32'hAB; t.mw = 1; t.size = 2'b00; t.g = 2;
        run_txn(t);
        chk("sb_addr", seen_addr, 32'h100);
        chk("sb_be", seen_be, 4'b1000);
        chk("sb_wdata", seen_wdata, 32'hABAB_ABAB);

        t = mk(); t.alu = 32'h202; t.mr = 1; t.size = 2'b01; t.rdat = 32'h8001_7FFF; t.rw = 1; t.wreg = 9;
        run_txn(t);
        chk("lh_signed", wb_data_o, 32'hFFFF_8001);
        t.uns = 1;
        run_txn(t);
        chk("lhu_unsigned", wb_data_o, 32'h0000_8001);

        t = mk(); t.alu = 32'h206; t.mr = 1; t.size = 2'b10; t.rw = 1; t.wreg = 3;
        run_txn(t);
        chk("lw_mis_pulse", misaligned_o, 1);
        chk("lw_mis_rw", wb_reg_write_o, 0);

        t = mk(); t.br = 1; t.zero = 1; t.jp = 32'h40;
        run_txn(t);
        chk("br_taken", branch_taken_o, 1);
        chk("br_target", branch_target_o, 32'h40);
        t.zero = 0;
        run_txn(t);
        chk("br_not_taken", branch_taken_o, 0);

        // Reset while a granted load waits for rvalid
        c = cyc;
        ex[c+1].req = 1; ex[c+1].we = 0; ex[c+1].addr = 32'h300; ex[c+1].be = 4'b1111; ex[c+1].rdy = 0;
        ex[c+2].rdy = 0;
        ex_valid_i = 1; alu_out_i = 32'h300; mem_read_i = 1; mem_write_i = 0; branch_i = 0;
        mem_size_i = 2'b10; reg_write_i = 1; write_reg_i = 7;
        dmem_gnt_i = 0; dmem_rvalid_i = 0;
        step();
        ex_valid_i = 0; dmem_gnt_i = 1;
        step();
        dmem_gnt_i = 0; rst_i = 1;
        step();
        rst_i = 0; dmem_rvalid_i = 1; dmem_rdata_i = 32'h1234_5678;
        chk("rstw_ex_ready", ex_ready_o, 1);
        chk("rstw_req", dmem_req_o, 0);
        chk("rstw_wb_data", wb_data_o, 0);
        step();
        dmem_rvalid_i = 0;
        chk("rstw_no_wb", wb_valid_o, 0);
        step();

        for (int i = 0; i < 700 && cyc < MAXC - 40; i++) begin
            int kind;
            t = mk();
            kind = int'($urandom % 10);
            t.alu = $urandom; t.st_data = $urandom; t.jp = $urandom; t.rdat = $urandom;
            t.wreg = 5'($urandom); t.rw = 1'($urandom % 2); t.zero = 1'($urandom % 2);
            t.uns = 1'($urandom % 2); t.size = 2'($urandom);
            t.g = int'($urandom % 4); t.r = int'($urandom % 4);
            if (kind == 3) t.br = 1;
            else if (kind >= 4 && kind <= 6) t.mr = 1;
            else if (kind >= 7) begin
                t.mw = 1; t.mr = 1'($urandom % 2);
            end
            n = nbytes(t.size);
            if ($urandom % 3 != 0) t.alu = t.alu & ~32'(n - 1);
            run_txn(t);
            if ($urandom % 4 == 0) begin
                repeat ($urandom_range(1, 2)) begin
                    step();
                    noise();
                end
            end
        end
        step();
        done = 1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
